// File: rtl/puf_rng_collector.sv
// Collects 4-bit PUF RNG nibbles, packs eight into a 32-bit word and queues words in a FWFT FIFO.
// Optional repetition-count health test is built when PUF_RNG_HEALTH_EN is defined.
module puf_rng_collector #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [3:0]       rng4bit_i,
  input  logic             rng4bit_done_i,
  input  logic             rng_mode_i,
  output logic             es_rng_req_o,
  output logic [31:0]      es_data_o,
  output logic             es_valid_o,
  input  logic             es_ready_i,
  output logic [CNT_W-1:0] fifo_level_o,
  output logic             err_timeout_o,
  input  logic             clr_err_i
`ifdef PUF_RNG_HEALTH_EN
  ,output logic            health_fail_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, REQ} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       part_q, part_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic              halt;
  logic              push, pop;
  logic [31:0]       push_word;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       last_q;

`ifdef PUF_RNG_HEALTH_EN
  logic [4:0]        run_q, run_d;
  logic [3:0]        lnib_q, lnib_d;
  logic              hfail_q, hfail_d;
  assign halt          = err_q | hfail_q;
  assign health_fail_o = hfail_q;
`else
  assign halt = err_q;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    part_d    = part_q;
    tcnt_d    = tcnt_q;
    err_d     = clr_err_i ? 1'b0 : err_q;
    push      = 1'b0;
    push_word = '0;
`ifdef PUF_RNG_HEALTH_EN
    run_d     = run_q;
    lnib_d    = lnib_q;
    hfail_d   = clr_err_i ? 1'b0 : hfail_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable_i && rng_mode_i && (cnt_q < CNT_W'(DEPTH)) && !halt) begin
          state_d = REQ;
          tcnt_d  = '0;
        end
      end
      REQ: begin
        if (rng4bit_done_i) begin
          state_d = IDLE;
          part_d  = part_q | ({28'd0, rng4bit_i} << {idx_q, 2'b00});
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            push      = 1'b1;
            push_word = part_d;
            part_d    = '0;
          end
`ifdef PUF_RNG_HEALTH_EN
          run_d  = (rng4bit_i == lnib_q && run_q != '0) ? run_q + 5'd1 : 5'd1;
          lnib_d = rng4bit_i;
          // 16th identical nibble poisons the word being built, even if it would complete it
          if (run_d == 5'd16) begin
            hfail_d = 1'b1;
            run_d   = '0;
            idx_d   = '0;
            part_d  = '0;
            push    = 1'b0;
          end
`endif
        end else if (!enable_i || !rng_mode_i) begin
          state_d = IDLE;
          idx_d   = '0;
          part_d  = '0;
`ifdef PUF_RNG_HEALTH_EN
          run_d   = '0;
`endif
        end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          part_d  = '0;
          err_d   = 1'b1;
`ifdef PUF_RNG_HEALTH_EN
          run_d   = '0;
`endif
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      part_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`ifdef PUF_RNG_HEALTH_EN
      run_q   <= '0;
      lnib_q  <= '0;
      hfail_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`ifdef PUF_RNG_HEALTH_EN
      run_q   <= run_d;
      lnib_q  <= lnib_d;
      hfail_q <= hfail_d;
`endif
    end
  end

  assign es_rng_req_o  = (state_q == REQ);
  assign err_timeout_o = err_q;

  assign es_valid_o   = (cnt_q != '0);
  assign pop          = es_valid_o & es_ready_i;
  assign fifo_level_o = cnt_q;
  // last_q keeps the most recently popped word so the output holds while empty
  assign es_data_o    = es_valid_o ? mem[rd_q] : last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop) begin
        rd_q   <= rd_q + PTR_W'(1);
        last_q <= mem[rd_q];
      end
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= push_word;
  end

endmodule
